cp0_irq: RTL and testbench
==========================

Name: cp0_irq

Overview:
Parametrised coprocessor-0 successor for the single-cycle MIPS core. Adds interrupt sources, masking, priority resolution, a Count/Compare timer and nested-exception protection (EXL) to the EPC/Cause/Status register set. Sits beside the register file. Drives the PC mux with trap/eret targets in the same cycle and commits state on the clock edge.

Parameters:
NUM_IRQ, 3, external interrupt lines (1..16); the timer is source index NUM_IRQ
DATA_W, 32, register/datapath width (fixed 32 in this generation; checked at elaboration)
HANDLER_ADDR, 32'h0000_4180, exception vector driven on handler_pc
COUNT_EN, 1, 1 = Count increments every cycle; 0 = Count is held except on writes

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enable  in  1  instruction commit qualifier; low = stall, no architectural update
we  in  1  mtc0 write strobe
sel  in  3  register select: 0 EPC, 1 Cause, 2 Status, 3 Count, 4 Compare; 5-7 reserved
din  in  32  mtc0 write data
dout  out  32  mfc0 read data (combinational on sel; reserved sel -> 0)
pc_in  in  32  PC of the committing instruction
exc_valid  in  1  synchronous exception from the decoder (syscall, RI, overflow)
exc_code  in  5  ExcCode for exc_valid
eret  in  1  ERET committing
irq_in  in  NUM_IRQ  level-sensitive interrupt lines, synchronous to clk
trap  out  1  redirect PC to handler_pc this cycle
handler_pc  out  32  HANDLER_ADDR
epc_out  out  32  current EPC (ERET target)

Behaviour:
- Reset (async, rst=1):
  - EPC, Cause, Status, Count and Compare clear to 0.
  - trap = 0; dout follows sel over the cleared registers.
- Status: bit0 IE, bit1 EXL, bits [8+NUM_IRQ:8] IM (mask, one bit per source including timer); other bits read 0 and are write-ignored.
- Cause: bits [6:2] ExcCode; bits [8+NUM_IRQ:8] IP (pending); bit31 BD reads 0; other bits read 0.
- IP latching (independent of enable):
  - IP[i] <= 1 on any cycle irq_in[i]=1.
  - IP[NUM_IRQ] (timer) <= 1 on the edge where Count==Compare and Compare != 0.
- IP clearing:
  - External bits are write-1-to-clear via mtc0 to Cause.
  - The timer bit clears on any mtc0 write to Compare.
  - A set and a clear in the same cycle: set wins.
- Count: +1 per cycle when COUNT_EN, wraps 32'hFFFF_FFFF -> 0. An mtc0 write to Count loads din and suppresses that cycle's increment. Count runs regardless of enable.
- Trap (combinational): trap = enable & ~EXL & (exc_valid | (IE & |(IP & IM))).
- Priority:
  - exc_valid beats interrupts.
  - Among interrupts, the lowest index wins; the timer is lowest priority.
  - Interrupt ExcCode = 0.
- On the edge with trap=1:
  - EPC <= pc_in; EXL <= 1; ExcCode <= exc_code or 0.
  - Any same-cycle mtc0 to EPC/Status/Cause is discarded. Trap wins, including over a written EXL/IE.
  - A same-cycle eret is ignored.
- On the edge with enable & eret & ~trap: EXL <= 0. epc_out is the PC target that cycle. An interrupt still pending traps no earlier than the next enabled cycle.
- mtc0 (enable & we & ~trap): writes only the writable fields of the selected register. Writing EPC is a full 32-bit load.
- EXL=1 blocks both interrupts and exc_valid traps. An exc_valid while EXL=1 is dropped; the core treats it as a fatal case (asserted in simulation).
- enable=0:
  - trap forced 0; no EPC/Status/ExcCode update.
  - IP and Count continue.
- Latency:
  - IP bit set -> trap: 1 edge (visible the cycle after irq_in rises, if unmasked).
  - Count==Compare -> timer IP: 1 edge.

Decomposition:
- Package cp0_pkg holds:
  - sel encodings (SEL_EPC..SEL_COMPARE);
  - Status/Cause bit positions (ST_IE, ST_EXL, IM_LSB, IP_LSB, EXCCODE_MSB/LSB);
  - ExcCode constants (EXC_INT=0, EXC_SYS=8, EXC_RI=10, EXC_OV=12).
- One sub-module, cp0_timer: Count/Compare registers, write handling, wrap and match pulse.
- The priority encoder stays inline as a function in cp0_irq.

Test Plan:
- Reset mid-run: assert rst with Count=5, EXL=1 -> all registers read 0 on the same cycle, trap=0.
- Masked vs unmasked:
  - Status=32'h0000_0101 (IE, IM0), irq_in=3'b001 one cycle, pc_in=32'h40 -> next cycle trap=1; after the edge EPC=32'h40, EXL=1, ExcCode=0.
  - With IM0=0 -> trap stays 0 while IP0=1.
- Priority and sync exception:
  - irq_in=3'b110 with IM=all, IE=1 -> trap resolves to source 1.
  - exc_valid=1, exc_code=8 in the same cycle -> ExcCode=8.
- ERET/EXL:
  - Under EXL=1, an irq yields trap=0.
  - eret -> EXL=0, epc_out=EPC; the next enabled cycle traps on the still-set IP.
  - trap+eret+mtc0 Status in one cycle -> trap effects only.
- Timer:
  - Compare=10, Count=8, IM[NUM_IRQ]=1, IE=1 -> timer IP set on the edge where Count==10; trap follows one cycle later.
  - Write Compare -> timer IP clears.
  - Count=32'hFFFF_FFFF wraps to 0.
- Stall and W1C:
  - With enable=0 and a pending unmasked IP -> trap=0, EPC unchanged, Count still increments.
  - mtc0 Cause din=32'h100 clears IP0 unless irq_in[0]=1 in that cycle.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt/exception block:
// register select codes, Status/Cause field positions and ExcCodes.
package cp0_pkg;

  localparam logic [2:0] SEL_EPC     = 3'd0;
  localparam logic [2:0] SEL_CAUSE   = 3'd1;
  localparam logic [2:0] SEL_STATUS  = 3'd2;
  localparam logic [2:0] SEL_COUNT   = 3'd3;
  localparam logic [2:0] SEL_COMPARE = 3'd4;

  localparam int ST_IE       = 0;
  localparam int ST_EXL      = 1;
  localparam int IM_LSB      = 8;
  localparam int IP_LSB      = 8;
  localparam int EXCCODE_MSB = 6;
  localparam int EXCCODE_LSB = 2;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter with software load, a
// Compare register, and a match flag feeding the timer pending bit.
module cp0_timer import cp0_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter bit COUNT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              match
);

  // A software load of Count takes the place of that cycle's increment;
  // the increment wraps naturally at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count_we) begin
      count <= din;
    end else if (COUNT_EN) begin
      count <= count + 1'b1;
    end
  end

  // Compare only changes on an explicit write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= '0;
    end else if (compare_we) begin
      compare <= din;
    end
  end

  // A zero Compare means the timer is disarmed.
  always_comb begin
    match = (count == compare) && (compare != '0);
  end

endmodule

// File: rtl/cp0_irq.sv
// Coprocessor-0 with interrupt sources, masking, priority resolution,
// a Count/Compare timer and EXL nested-exception protection. The trap
// decision is combinational so the PC mux can redirect in the same
// cycle; all architectural state commits on the clock edge.
module cp0_irq import cp0_pkg::*; #(
  parameter int          NUM_IRQ      = 3,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter bit          COUNT_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               we,
  input  logic [2:0]         sel,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               trap,
  output logic [DATA_W-1:0]  handler_pc,
  output logic [DATA_W-1:0]  epc_out
);

  // Pending/mask vectors carry one bit per external line plus the timer.
  localparam int NIP = NUM_IRQ + 1;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("cp0_irq: DATA_W must be 32");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
    $error("cp0_irq: NUM_IRQ must be in 1..16");
  end

  logic [DATA_W-1:0] epc;
  logic [NIP-1:0]    ip;
  logic [NIP-1:0]    im;
  logic              ie;
  logic              exl;
  logic [4:0]        exc_code_q;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] compare;
  logic              timer_match;
  logic              wr_ok;
  logic [NIP-1:0]    irq_grant;
  logic              int_req;
  logic [NIP-1:0]    ip_set;
  logic [NIP-1:0]    ip_clr;
  logic [DATA_W-1:0] cause_rd;
  logic [DATA_W-1:0] status_rd;

  // One-hot grant of the lowest-index request; the timer sits at the top
  // index and so loses to every external line.
  function automatic logic [NIP-1:0] prio_grant(input logic [NIP-1:0] req);
    logic [NIP-1:0] g;
    logic           found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NIP; i++) begin
      if (req[i] && !found) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  cp0_timer #(
    .DATA_W   (DATA_W),
    .COUNT_EN (COUNT_EN)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_ok && (sel == SEL_COUNT)),
    .compare_we (wr_ok && (sel == SEL_COMPARE)),
    .din        (din),
    .count      (count),
    .compare    (compare),
    .match      (timer_match)
  );

  // Trap decision: sync exceptions and unmasked interrupts, blocked while
  // stalled or already inside a handler. mtc0 only lands when not trapping.
  always_comb begin
    irq_grant = prio_grant(ip & im);
    int_req   = |irq_grant;
    trap      = enable && !exl && (exc_valid || (ie && int_req));
    wr_ok     = enable && we && !trap;
  end

  // Pending-bit sources and clears; the OR after masking makes set win.
  always_comb begin
    ip_set = {timer_match, irq_in};
    ip_clr = '0;
    if (wr_ok && (sel == SEL_CAUSE)) begin
      ip_clr[NUM_IRQ-1:0] = din[IP_LSB +: NUM_IRQ];
    end
    if (wr_ok && (sel == SEL_COMPARE)) begin
      ip_clr[NUM_IRQ] = 1'b1;
    end
  end

  // IP tracks the lines every cycle, independent of commit stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip <= '0;
    end else begin
      ip <= (ip & ~ip_clr) | ip_set;
    end
  end

  // Architectural EPC/Status/ExcCode: trap beats eret beats mtc0 for EXL,
  // and a trap discards any mtc0 in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc        <= '0;
      ie         <= 1'b0;
      exl        <= 1'b0;
      im         <= '0;
      exc_code_q <= '0;
    end else if (trap) begin
      epc        <= pc_in;
      exl        <= 1'b1;
      exc_code_q <= exc_valid ? exc_code : EXC_INT;
    end else if (enable) begin
      if (wr_ok && (sel == SEL_EPC)) begin
        epc <= din;
      end
      if (wr_ok && (sel == SEL_STATUS)) begin
        ie  <= din[ST_IE];
        exl <= din[ST_EXL];
        im  <= din[IM_LSB +: NIP];
      end
      if (eret) begin
        exl <= 1'b0;
      end
    end
  end

  // Read mux over the assembled register images; reserved selects read 0.
  always_comb begin
    cause_rd                              = '0;
    cause_rd[EXCCODE_MSB:EXCCODE_LSB]     = exc_code_q;
    cause_rd[IP_LSB +: NIP]               = ip;
    status_rd                             = '0;
    status_rd[ST_IE]                      = ie;
    status_rd[ST_EXL]                     = exl;
    status_rd[IM_LSB +: NIP]              = im;
    case (sel)
      SEL_EPC:     dout = epc;
      SEL_CAUSE:   dout = cause_rd;
      SEL_STATUS:  dout = status_rd;
      SEL_COUNT:   dout = count;
      SEL_COMPARE: dout = compare;
      default:     dout = '0;
    endcase
    handler_pc = HANDLER_ADDR;
    epc_out    = epc;
  end

  // A synchronous exception arriving inside a handler is unrecoverable.
  assert property (@(posedge clk) disable iff (rst) !(enable && exc_valid && exl));

endmodule

// File: tb/tb_cp0_irq.sv
// Directed testbench for cp0_irq with hand-computed expectations.
module tb_cp0_irq;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        we;
  logic [2:0]  sel;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc_in;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic [2:0]  irq_in;
  logic        trap;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int checks;
  int failures;

  cp0_irq dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .we         (we),
    .sel        (sel),
    .din        (din),
    .dout       (dout),
    .pc_in      (pc_in),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .eret       (eret),
    .irq_in     (irq_in),
    .trap       (trap),
    .handler_pc (handler_pc),
    .epc_out    (epc_out)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One mtc0 on a single committing cycle.
  task automatic mtc0(input logic [2:0] s, input logic [31:0] d);
    we  = 1'b1;
    sel = s;
    din = d;
    applyStimulus();
    we  = 1'b0;
  endtask

  // Check a register read through the combinational dout mux.
  task automatic checkReg(input string tag, input logic [2:0] s, input logic [31:0] exp);
    sel = s;
    #1;
    checkOutput(tag, dout, exp);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    we        = 1'b0;
    sel       = 3'd0;
    din       = '0;
    pc_in     = '0;
    exc_valid = 1'b0;
    exc_code  = '0;
    eret      = 1'b0;
    irq_in    = '0;
    #12;
    checkReg("rst_epc", 3'd0, 32'h0);
    checkReg("rst_cause", 3'd1, 32'h0);
    checkReg("rst_status", 3'd2, 32'h0);
    checkReg("rst_count", 3'd3, 32'h0);
    checkReg("rst_compare", 3'd4, 32'h0);
    checkReg("rst_reserved", 3'd6, 32'h0);
    checkOutput("rst_trap", {31'b0, trap}, 32'h0);
    checkOutput("handler_pc", handler_pc, 32'h0000_4180);
    rst = 1'b0;
    applyStimulus();

    // Unmasked external interrupt 0.
    mtc0(3'd2, 32'h0000_0101);
    irq_in = 3'b001;
    pc_in  = 32'h40;
    #1;
    checkOutput("trap_before_latch", {31'b0, trap}, 32'h0);
    applyStimulus();
    irq_in = 3'b000;
    #1;
    checkOutput("trap_after_latch", {31'b0, trap}, 32'h1);
    applyStimulus();
    checkReg("int_epc", 3'd0, 32'h40);
    checkReg("int_status_exl", 3'd2, 32'h0000_0103);
    checkReg("int_cause", 3'd1, 32'h0000_0100);
    checkOutput("exl_blocks", {31'b0, trap}, 32'h0);

    // Under EXL a new interrupt does not trap.
    mtc0(3'd2, 32'h0000_0F03);
    irq_in = 3'b010;
    applyStimulus();
    irq_in = 3'b000;
    #1;
    checkOutput("exl_irq_no_trap", {31'b0, trap}, 32'h0);

    // ERET returns to EPC; pending IP traps on the next enabled cycle.
    eret = 1'b1;
    #1;
    checkOutput("eret_epc_out", epc_out, 32'h40);
    checkOutput("eret_no_trap", {31'b0, trap}, 32'h0);
    applyStimulus();
    eret = 1'b0;
    checkReg("eret_status", 3'd2, 32'h0000_0F01);
    checkOutput("post_eret_trap", {31'b0, trap}, 32'h1);

    // Trap + eret + mtc0 Status in the same cycle: trap effects only.
    eret  = 1'b1;
    pc_in = 32'h80;
    mtc0(3'd2, 32'h0);
    eret  = 1'b0;
    checkReg("combo_epc", 3'd0, 32'h80);
    checkReg("combo_status", 3'd2, 32'h0000_0F03);
    checkReg("combo_cause", 3'd1, 32'h0000_0300);

    // Clear pending, leave handler.
    mtc0(3'd1, 32'h0000_0300);
    checkReg("w1c_cause", 3'd1, 32'h0);
    eret = 1'b1;
    applyStimulus();
    eret = 1'b0;
    checkReg("eret2_status", 3'd2, 32'h0000_0F01);

    // Two interrupts plus a syscall: the sync exception wins.
    irq_in = 3'b110;
    applyStimulus();
    irq_in = 3'b000;
    #1;
    checkOutput("prio_trap", {31'b0, trap}, 32'h1);
    exc_valid = 1'b1;
    exc_code  = 5'd8;
    pc_in     = 32'h100;
    applyStimulus();
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    checkReg("sys_cause", 3'd1, 32'h0000_0620);
    checkReg("sys_epc", 3'd0, 32'h100);

    // W1C: set wins over clear in the same cycle.
    irq_in = 3'b001;
    mtc0(3'd1, 32'h0000_0100);
    irq_in = 3'b000;
    checkReg("w1c_set_wins", 3'd1, 32'h0000_0720);
    mtc0(3'd1, 32'h0000_0100);
    checkReg("w1c_clear", 3'd1, 32'h0000_0620);
    mtc0(3'd1, 32'h0000_0600);

    // Masked interrupt stays pending without trapping.
    mtc0(3'd2, 32'h0000_0E01);
    irq_in = 3'b001;
    applyStimulus();
    irq_in = 3'b000;
    #1;
    checkOutput("masked_no_trap", {31'b0, trap}, 32'h0);
    checkReg("masked_cause", 3'd1, 32'h0000_0120);

    // Stall: pending unmasked IP, no trap, Count keeps running.
    mtc0(3'd3, 32'd100);
    mtc0(3'd2, 32'h0000_0F01);
    enable = 1'b0;
    #1;
    checkOutput("stall_no_trap", {31'b0, trap}, 32'h0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkReg("stall_count", 3'd3, 32'd104);
    checkReg("stall_epc", 3'd0, 32'h100);
    enable = 1'b1;
    #1;
    checkOutput("unstall_trap", {31'b0, trap}, 32'h1);
    pc_in = 32'h200;
    applyStimulus();
    checkReg("unstall_epc", 3'd0, 32'h200);
    mtc0(3'd1, 32'h0000_0100);

    // Timer: Compare=10, Count=8 -> IP set on the edge where Count==10.
    mtc0(3'd4, 32'd10);
    mtc0(3'd3, 32'd8);
    eret = 1'b1;
    applyStimulus();
    eret = 1'b0;
    checkReg("tmr_count9", 3'd3, 32'd9);
    checkOutput("tmr_no_trap9", {31'b0, trap}, 32'h0);
    applyStimulus();
    checkReg("tmr_cause10", 3'd1, 32'h0);
    applyStimulus();
    checkReg("tmr_cause_set", 3'd1, 32'h0000_0800);
    checkOutput("tmr_trap", {31'b0, trap}, 32'h1);
    pc_in = 32'h300;
    applyStimulus();
    mtc0(3'd4, 32'h0);
    checkReg("tmr_cleared", 3'd1, 32'h0);

    // Count wrap.
    mtc0(3'd3, 32'hFFFF_FFFF);
    checkReg("wrap_pre", 3'd3, 32'hFFFF_FFFF);
    applyStimulus();
    checkReg("wrap_post", 3'd3, 32'h0);

    // Reset mid-run with Count=5 and EXL=1.
    mtc0(3'd3, 32'd5);
    checkReg("pre_rst_count", 3'd3, 32'd5);
    rst = 1'b1;
    checkReg("mid_rst_count", 3'd3, 32'h0);
    checkReg("mid_rst_status", 3'd2, 32'h0);
    checkReg("mid_rst_epc", 3'd0, 32'h0);
    checkReg("mid_rst_cause", 3'd1, 32'h0);
    checkOutput("mid_rst_trap", {31'b0, trap}, 32'h0);
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
